// File: rtl/uart_8n1_pkg.sv
// Shared UART 8N1 constants, receiver state encoding and helpers.
// Used by the receiver (and the transmitter) for OVERSAMPLE and DATA_BITS.
package uart_8n1_pkg;

   localparam int unsigned OVERSAMPLE  = 16;
   localparam int unsigned DATA_BITS   = 8;
   localparam int unsigned SAMPLE_TICK = 7;
   localparam int unsigned TICK_W      = $clog2(OVERSAMPLE);
   localparam int unsigned BIT_IDX_W   = $clog2(DATA_BITS);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_e;

   // 2-of-3 majority
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous bit, reset to 1 (idle line).
// Ports:
//   clk_baud_16x - sampling clock
//   reset        - synchronous active-high reset
//   d_i          - asynchronous input
//   q_o          - synchronised output, STAGES cycles later
module uart_sync_bit #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk_baud_16x,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk_baud_16x) begin
      if (reset) sync_q <= '1;
      else       sync_q <= {sync_q[STAGES-2:0], d_i};
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_8n1_receiver.sv
// UART 8N1 receiver, 16x oversampled, LSB first.
// Optional macro UART_RX_MAJORITY_VOTE_EN: bit value is the majority of ticks
// 6/7/8 with decisions at tick 8; otherwise a single sample at tick 7.
// Ports:
//   clk_baud_16x - clock, 16 per bit
//   reset        - synchronous active-high reset
//   rx           - asynchronous serial line, idle high
//   recv_data    - last correctly framed byte
//   recv_valid   - one-cycle pulse, recv_data updated
//   recv_error   - one-cycle pulse, stop bit sampled low
//   recv_busy    - high from start detection until frame done/rejected
module uart_8n1_receiver
   import uart_8n1_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                 clk_baud_16x,
   input  logic                 reset,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] recv_data,
   output logic                 recv_valid,
   output logic                 recv_error,
   output logic                 recv_busy
);

   localparam logic [TICK_W-1:0]    LAST_TICK = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_IDX_W-1:0] LAST_BIT  = BIT_IDX_W'(DATA_BITS - 1);

   logic                 rxs;
   rx_state_e            state_q, state_d;
   logic [TICK_W-1:0]    tick_q, tick_d;
   logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 error_q, error_d;
   logic                 busy_q, busy_d;
   logic                 rxs_d1_q, rxs_d2_q;
   logic                 bit_val_c;

   uart_sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
      .clk_baud_16x (clk_baud_16x),
      .reset        (reset),
      .d_i          (rx),
      .q_o          (rxs)
   );

   // rxs_d1_q lines the sample up with the tick counter: the counter starts one
   // cycle after the first low rxs, so tick N sees line position N of the cell.
`ifdef UART_RX_MAJORITY_VOTE_EN
   localparam logic [TICK_W-1:0] DECIDE_TICK = TICK_W'(SAMPLE_TICK + 1);
   logic vote_a_q, vote_b_q;

   // capture ticks 6 and 7; tick 8 is the live sample
   always_ff @(posedge clk_baud_16x) begin
      if (reset) begin
         vote_a_q <= 1'b1;
         vote_b_q <= 1'b1;
      end else begin
         if (tick_q == TICK_W'(SAMPLE_TICK - 1)) vote_a_q <= rxs_d1_q;
         if (tick_q == TICK_W'(SAMPLE_TICK))     vote_b_q <= rxs_d1_q;
      end
   end

   assign bit_val_c = maj3(vote_a_q, vote_b_q, rxs_d1_q);
`else
   localparam logic [TICK_W-1:0] DECIDE_TICK = TICK_W'(SAMPLE_TICK);
   assign bit_val_c = rxs_d1_q;
`endif

   // state and datapath registers
   always_ff @(posedge clk_baud_16x) begin
      if (reset) begin
         state_q   <= IDLE;
         tick_q    <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         error_q   <= 1'b0;
         busy_q    <= 1'b0;
         rxs_d1_q  <= 1'b1;
         rxs_d2_q  <= 1'b1;
      end else begin
         state_q   <= state_d;
         tick_q    <= tick_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         error_q   <= error_d;
         busy_q    <= busy_d;
         rxs_d1_q  <= rxs;
         rxs_d2_q  <= rxs_d1_q;
      end
   end

   // next-state and output logic
   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q + TICK_W'(1);
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      error_d   = 1'b0;
      busy_d    = busy_q;

      case (state_q)
         IDLE: begin
            tick_d = '0;
            // IDLE is only entered with the line seen high, so low rxs is a
            // fresh start edge. If it fell while the previous stop bit was still
            // being decided, start the counter ahead to stay on the cell grid.
            if (!rxs) begin
               state_d = START;
               busy_d  = 1'b1;
               if (!rxs_d1_q && !rxs_d2_q) tick_d = TICK_W'(2);
               else if (!rxs_d1_q)         tick_d = TICK_W'(1);
            end
         end
         START: begin
            if (tick_q == DECIDE_TICK && bit_val_c) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               tick_d  = '0;
            end else if (tick_q == LAST_TICK) begin
               state_d   = DATA;
               bit_idx_d = '0;
            end
         end
         DATA: begin
            if (tick_q == DECIDE_TICK) shift_d = {bit_val_c, shift_q[DATA_BITS-1:1]};
            if (tick_q == LAST_TICK) begin
               if (bit_idx_q == LAST_BIT) state_d = STOP;
               else bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
            end
         end
         STOP: begin
            if (tick_q == DECIDE_TICK) begin
               tick_d    = '0;
               bit_idx_d = '0;
               if (bit_val_c) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  error_d = 1'b1;
                  state_d = BREAK;
               end
            end
         end
         BREAK: begin
            tick_d = '0;
            if (rxs) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            tick_d  = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign recv_data  = data_q;
   assign recv_valid = valid_q;
   assign recv_error = error_q;
   assign recv_busy  = busy_q;

endmodule

// File: doc/uart_8n1_receiver.md
UART_8N1_RECEIVER -- requirements
Module: uart_8n1_receiver

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of flops synchronising rx into the clk_baud_16x domain (legal 2..4).
REQ-002 clk_baud_16x  input  1  clock, 16 pulses per baud; reset reset, synchronous, active-high; clock clk_baud_16x.
REQ-003 reset  input  1  synchronous active-high reset, sampled on rising clk_baud_16x.
REQ-004 rx  input  1  asynchronous incoming UART line, idle high.
REQ-005 recv_data  output  8  last correctly framed byte, LSB received first.
REQ-006 recv_valid  output  1  one-cycle pulse: recv_data updated with a new byte.
REQ-007 recv_error  output  1  one-cycle pulse: framing error (stop bit sampled low).
REQ-008 recv_busy  output  1  high from start-edge detection until the frame completes or is rejected.

Function
REQ-009 rx SHALL pass through SYNC_STAGES flops before any use; all timing below refers to the synchronised signal rxs.
REQ-010 States SHALL be IDLE, START, DATA, STOP, BREAK, with a 4-bit tick counter and a 3-bit bit index.
REQ-011 IDLE: a high-to-low transition of rxs SHALL enter START with tick=0 and assert recv_busy on the same edge.
REQ-012 Every bit cell SHALL be 16 ticks; the sample point SHALL be tick 7 (see REQ-022).
REQ-013 START: if the sample at tick 7 is high, the block SHALL return to IDLE (false start, no pulse, recv_busy low); otherwise it SHALL enter DATA at tick 15 with bit index 0.
REQ-014 DATA: each sampled bit SHALL shift into an internal register MSB-ward (LSB first on the line); after bit index 7 at tick 15 the block SHALL enter STOP.
REQ-015 STOP, sample high: at the tick-7 edge the block SHALL load recv_data, pulse recv_valid for exactly one cycle, deassert recv_busy, and enter IDLE.
REQ-016 STOP, sample low: the block SHALL pulse recv_error for one cycle, leave recv_data unchanged, keep recv_busy high, and enter BREAK.
REQ-017 BREAK: the block SHALL remain until rxs is high, then enter IDLE and deassert recv_busy on that edge.
REQ-018 Returning to IDLE at the stop-bit midpoint SHALL allow a start edge arriving 8 or more ticks later to be received; back-to-back frames SHALL be lost neither at transmitter stop length 9.5 nor at stop length 10 bits.
REQ-019 recv_valid and recv_error SHALL never be asserted in the same cycle.
REQ-020 Latency: recv_valid SHALL rise SYNC_STAGES+1 cycles after the stop-bit sample point on the raw rx line (nominally 8 ticks after the stop-bit edge plus synchroniser delay).

Reset
REQ-021 reset SHALL take effect on the next clk_baud_16x edge from any state, mid-frame included: state IDLE, counters 0, synchroniser flops 1, recv_data 8'h00, recv_valid 0, recv_error 0, recv_busy 0; no partial byte SHALL be reported.

Configuration
REQ-022 With UART_RX_MAJORITY_VOTE_EN defined, every bit value SHALL be the 2-of-3 majority of rxs at ticks 6, 7, 8, and decisions SHALL take effect at tick 8; without it, a single sample at tick 7 SHALL be used.

Structure
REQ-023 Shared package uart_8n1_pkg SHALL hold OVERSAMPLE=16, DATA_BITS=8, SAMPLE_TICK=7, and the receiver state enum; the transmitter SHALL also use OVERSAMPLE and DATA_BITS.
REQ-024 The synchroniser SHALL be a separate sub-module uart_sync_bit (parameter STAGES, reset value 1); all other logic SHALL be in one module.

Verification
REQ-025 Byte 8'hA5, ideal timing -> one recv_valid pulse, recv_data=8'hA5, recv_error never high, recv_busy high for the whole frame.
REQ-026 Low glitch of 4 ticks on an idle line -> return to IDLE, no recv_valid, no recv_error, recv_busy low within 10 cycles.
REQ-027 Byte 8'h3C with stop bit forced low, then line high after 32 ticks -> one recv_error pulse, recv_data keeps previous value, recv_busy falls when rx rises.
REQ-028 Bytes 8'h00, 8'hFF, 8'h55 back-to-back with 9.5-bit frame spacing -> three recv_valid pulses in order with matching data.
REQ-029 reset asserted during bit 4 of 8'h81, then 8'h7E sent -> outputs zero after reset, exactly one recv_valid with recv_data=8'h7E.
REQ-030 With UART_RX_MAJORITY_VOTE_EN: single-tick inversion at tick 7 of every data bit of 8'hC3 -> recv_data=8'hC3; without the macro the same stimulus -> recv_data=8'h3C.
